// File: rtl/pipe_adder_if.sv
// pipe_adder_if: operation/result handshake bundle for pipe_adder.
//   I_valid/O_ready      : operation handshake (upstream -> adder)
//   I_a, I_b             : operands, WIDTH bits
//   I_cin, I_sub         : carry/borrow-in, add(0)/subtract(1) select
//   O_valid/I_ready      : result handshake (adder -> downstream)
//   O_sum, O_cout, O_ovf : result, carry-out (sub: 1 = no borrow), signed overflow
// master: the side that issues operations and consumes results.
// slave : the adder itself.
interface pipe_adder_if #(
  parameter int WIDTH = 16
);
  logic             I_valid;
  logic             O_ready;
  logic [WIDTH-1:0] I_a;
  logic [WIDTH-1:0] I_b;
  logic             I_cin;
  logic             I_sub;
  logic             O_valid;
  logic             I_ready;
  logic [WIDTH-1:0] O_sum;
  logic             O_cout;
  logic             O_ovf;

  modport master (
    output I_valid, I_a, I_b, I_cin, I_sub, I_ready,
    input  O_ready, O_valid, O_sum, O_cout, O_ovf
  );

  modport slave (
    input  I_valid, I_a, I_b, I_cin, I_sub, I_ready,
    output O_ready, O_valid, O_sum, O_cout, O_ovf
  );
endinterface

// File: rtl/pipe_adder.sv
// pipe_adder: pipelined two's-complement adder/subtractor.
// The WIDTH-bit carry chain is cut into SEG segments of WIDTH/SEG bits; each
// segment is added in its own register stage, so latency is SEG cycles and
// throughput is one operation per cycle. The whole pipeline stalls as a unit
// when the output holds a result that downstream has not taken.
// Ports:
//   I_clk : clock, rising edge
//   I_rst : synchronous reset, active-high (clears valids and output regs)
//   bus   : pipe_adder_if.slave (operation in, result out, valid/ready both sides)
module pipe_adder #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic        I_clk,
  input  logic        I_rst,
  pipe_adder_if.slave bus
);

  localparam int L   = WIDTH / SEG;
  localparam int MSB = WIDTH - 1;

  // One segment of the carry chain: {carry_out, sum} of an L-bit add.
  function automatic logic [L:0] seg_add(input logic [L-1:0] x,
                                         input logic [L-1:0] y,
                                         input logic         c);
    return {1'b0, x} + {1'b0, y} + {{L{1'b0}}, c};
  endfunction

  // Per-stage inputs (w_*[k]) and registered state (r_*_p[k]).
  // r_x_p carries operand A with the already-added segments replaced by their
  // sum bits, so by the last stage it holds the full result. r_y_p carries B'
  // (B possibly inverted) unchanged for the higher segments and the MSB check.
  logic [WIDTH-1:0] w_x  [SEG];
  logic [WIDTH-1:0] w_y  [SEG];
  logic             w_c  [SEG];
  logic             w_v  [SEG];
  logic [L:0]       w_seg[SEG];
  logic [WIDTH-1:0] w_xn [SEG];
  logic             w_adv;

  logic [WIDTH-1:0] r_x_p  [SEG];
  logic [WIDTH-1:0] r_y_p  [SEG];
  logic             r_c_p  [SEG];
  logic             r_vld_p[SEG];
  logic             r_am;

  always_comb begin
    // The pipeline moves as one unit; only a held, untaken result blocks it.
    w_adv = !r_vld_p[SEG-1] || bus.I_ready;

    // Stage 0 input: subtraction folded into B' and the carry-in.
    w_x[0] = bus.I_a;
    w_y[0] = bus.I_sub ? ~bus.I_b : bus.I_b;
    w_c[0] = bus.I_cin ^ bus.I_sub;
    w_v[0] = bus.I_valid && w_adv;

    // Stage k input comes from the stage k-1 registers.
    for (int k = 1; k < SEG; k++) begin
      w_x[k] = r_x_p[k-1];
      w_y[k] = r_y_p[k-1];
      w_c[k] = r_c_p[k-1];
      w_v[k] = r_vld_p[k-1];
    end

    for (int k = 0; k < SEG; k++) begin
      w_seg[k]            = seg_add(w_x[k][k*L +: L], w_y[k][k*L +: L], w_c[k]);
      w_xn[k]             = w_x[k];
      w_xn[k][k*L +: L]   = w_seg[k][L-1:0];
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      for (int k = 0; k < SEG; k++) begin
        r_vld_p[k] <= 1'b0;
      end
      // Output-stage data is cleared so the result port reads zero after reset.
      r_x_p[SEG-1] <= '0;
      r_y_p[SEG-1] <= '0;
      r_c_p[SEG-1] <= 1'b0;
      r_am         <= 1'b0;
    end else if (w_adv) begin
      for (int k = 0; k < SEG; k++) begin
        r_vld_p[k] <= w_v[k];
        // Data only loads behind a valid op; bubbles leave it untouched.
        if (w_v[k]) begin
          r_x_p[k] <= w_xn[k];
          r_y_p[k] <= w_y[k];
          r_c_p[k] <= w_seg[k][L];
        end
      end
      // A's sign bit is overwritten by the final segment, so keep a copy.
      if (w_v[SEG-1]) begin
        r_am <= w_x[SEG-1][MSB];
      end
    end
  end

  // Output stage: all result bits come from registers.
  assign bus.O_ready = w_adv;
  assign bus.O_valid = r_vld_p[SEG-1];
  assign bus.O_sum   = r_x_p[SEG-1];
  assign bus.O_cout  = r_c_p[SEG-1];
  assign bus.O_ovf   = (r_am == r_y_p[SEG-1][MSB]) && (r_x_p[SEG-1][MSB] != r_am);

endmodule

// File: doc/pipe_adder.md
# pipe_adder

Parametrised, pipelined two's-complement adder/subtractor: the sequential successor of the single-bit combinational half adder. The WIDTH-bit carry chain is split into SEG equal segments, one register stage per segment, so wide adds close timing at full clock rate with one result per cycle. A valid/ready handshake on both sides lets the block sit directly in datapaths that apply backpressure. Per-operation add/subtract, carry/borrow-in, carry-out and signed overflow are provided.

## Interface
- WIDTH, default 16: operand and result width in bits; must be ≥ 2.
- SEG, default 4: number of carry-chain segments (= pipeline stages = latency); WIDTH % SEG == 0 is required; 1 ≤ SEG ≤ WIDTH.
- I_clk  in  1  clock, all state on rising edge.
- I_rst  in  1  synchronous reset, active-high.
- I_valid  in  1  input operation valid.
- O_ready  out  1  block can accept an operation this cycle.
- I_a  in  WIDTH  operand A.
- I_b  in  WIDTH  operand B.
- I_cin  in  1  carry-in (add) / borrow-in (subtract).
- I_sub  in  1  0: A + B + cin; 1: A − B − cin.
- O_valid  out  1  result valid.
- I_ready  in  1  downstream accepts result this cycle.
- O_sum  out  WIDTH  result, modulo 2^WIDTH.
- O_cout  out  1  carry out of MSB (subtract: 1 = no borrow).
- O_ovf  out  1  signed overflow.

## Operation
- Accept when I_valid && O_ready; result handed off when O_valid && I_ready.
- Arithmetic: B' = I_sub ? ~I_b : I_b; c0 = I_cin ^ I_sub; {O_cout, O_sum} = I_a + B' + c0 in WIDTH+1 bits.
- O_ovf = (a[MSB] == B'[MSB]) && (O_sum[MSB] != a[MSB]).
- Segment width L = WIDTH/SEG. Stage k (0..SEG−1) adds bits [k·L +: L] of A and B' with the carry registered by stage k−1 (stage 0 uses c0).
- Skew: operand slices for higher segments are delayed to their stage; completed lower sum slices are delayed to the output stage, so all WIDTH result bits of one operation emerge together.
- Each stage holds a valid bit; data registers load only when their stage advances. Operation order is preserved; no operation is dropped or duplicated.
- Stall: the whole pipeline advances iff adv = !O_valid || I_ready. O_ready = adv. When adv = 0, every stage register holds.
- Bubbles: when adv = 1 and no input is accepted, a 0 valid bit enters stage 0; bubbles propagate without stalling.
- I_a/I_b/I_cin/I_sub are ignored when not accepted.

## Timing
- Reset (I_rst high at clock edge): all valid bits 0; O_valid = 0, O_sum = 0, O_cout = 0, O_ovf = 0. O_ready = 1 in the first cycle after reset. Reset overrides any in-flight operation or stall; in-flight results are discarded, never emitted.
- Latency: operation accepted at edge n has O_valid = 1 after edge n+SEG−1 … i.e. visible in the cycle following edge n+SEG−1 (SEG register stages; SEG = 1 gives one registered cycle).
- Throughput: one operation per cycle while I_ready = 1.
- Output stability: while O_valid && !I_ready, O_sum/O_cout/O_ovf are held unchanged.
- Simultaneous accept and hand-off in the same cycle is legal and required for full throughput.
- O_ready is combinational from I_ready and O_valid only (no path from I_valid).
- Outputs are registered (no combinational path from I_a/I_b to O_sum).

## Test plan
- WIDTH=16, SEG=4: A=0xFFFF, B=0x0001, cin=0, add → after 4 cycles O_sum=0x0000, O_cout=1, O_ovf=0.
- A=0x7FFF, B=0x0001, add → O_sum=0x8000, O_cout=0, O_ovf=1; A=0x8000, B=0x0001, sub → O_sum=0x7FFF, O_cout=1, O_ovf=1.
- A=0x0005, B=0x0007, cin=1, sub → O_sum=0xFFFD, O_cout=0, O_ovf=0; carry across segment boundary: A=0x00FF, B=0x0001, add → 0x0100.
- Stream 8 back-to-back ops; hold I_ready=0 for 3 cycles mid-stream → O_ready=0 during stall, O_sum stable, all 8 results in order, none lost or duplicated.
- Assert I_rst for 1 cycle with 3 ops in flight → next cycle O_valid=0, outputs 0, O_ready=1; none of the 3 results ever appear.
- Parameter sweep (WIDTH,SEG) ∈ {(8,1),(16,4),(32,8),(8,8)}: 10k random ops with random I_valid/I_ready versus reference model → bit-exact sum/cout/ovf, latency SEG when unstalled.
